// File: rtl/memory.sv
// memory: single-port RAM, synchronous write, combinational read over a shared tri-state data bus.
module memory #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [DWIDTH-1:0] data,
  input  logic              read,
  input  logic              write,
  input  logic [AWIDTH-1:0] addr
);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  // A write while reading is dropped: the bus carries our own read data, not the master's.
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < 2**AWIDTH; i++) mem[i] <= '0;
    else if (write && !read)
      mem[addr] <= data;
  assign data = read ? mem[addr] : 'z;
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed self-checking bench for memory; the bus is pulled high so a released bus reads all ones.
module tb_memory;
  logic       clk = 0;
  logic       reset = 0;
  logic       read = 0;
  logic       write = 0;
  logic [4:0] addr = '0;
  logic [7:0] drv = '0;
  logic       oe = 0;
  tri1  [7:0] data;
  int         checks = 0;
  int         errors = 0;

  assign data = oe ? drv : 'z;

  memory #(.DWIDTH(8), .AWIDTH(5)) dut (
    .clk(clk), .reset(reset), .data(data), .read(read), .write(write), .addr(addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    read = 0; oe = 1; drv = d; addr = a; write = 1;
    @(posedge clk); #1;
    write = 0; oe = 0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
    oe = 0; read = 1; addr = a;
    #1 check(tag, data, exp);
    read = 0;
    #1;
  endtask

  initial begin
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 32; i++) rd("reset_read", 5'(i), 8'h00);
    #1 check("release_after_reset", data, 8'hFF);

    for (int i = 0; i < 32; i++) wr(5'(i), 8'h00);
    for (int i = 0; i < 32; i++) rd("zero_fill", 5'(i), 8'h00);

    for (int i = 0; i < 32; i++) wr(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) rd("data_eq_addr", 5'(i), 8'(i));

    oe = 0; read = 1; addr = 5'd3; write = 1;
    #1 check("bus_during_blocked_write", data, 8'h03);
    @(posedge clk); #1;
    write = 0;
    check("bus_after_blocked_write", data, 8'h03);
    read = 0;
    rd("addr3_kept", 5'd3, 8'h03);

    wr(5'd7, 8'h11);
    wr(5'd7, 8'h22);
    rd("last_write_wins", 5'd7, 8'h22);

    read = 0; oe = 1; drv = 8'h5A; addr = 5'd31; write = 1; reset = 1;
    @(posedge clk); #1;
    write = 0; oe = 0; reset = 0;
    rd("reset_beats_write", 5'd31, 8'h00);
    rd("reset_clears_5", 5'd5, 8'h00);
    rd("reset_clears_7", 5'd7, 8'h00);
    wr(5'd31, 8'h5A);
    rd("write_after_reset", 5'd31, 8'h5A);

    for (int i = 0; i < 32; i++) wr(5'(i), 8'(i + 8'h40));
    read = 1;
    for (int i = 0; i < 32; i++) begin
      addr = 5'(i);
      #1 check("sweep", data, 8'(i + 8'h40));
    end
    read = 0;
    #1 check("release_after_sweep", data, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
